// File: rtl/prf_mp_if.sv
// Issue/complete/dispatch bundle for the physical register file: read tags out, operands and ready bits back,
// plus CDB writes and dispatch allocations. The master is the pipeline side and the slave is the register file.
interface prf_mp_if #(
  parameter int PHYS_REG_SZ = 64,
  parameter int XLEN        = 32,
  parameter int NUM_RD      = 4,
  parameter int NUM_WR      = 2,
  parameter int NUM_ALLOC   = 2,
  parameter int TAG_W       = $clog2(PHYS_REG_SZ)
);
  logic [NUM_RD-1:0][TAG_W-1:0]    rd_tag;
  logic [NUM_RD-1:0][XLEN-1:0]     rd_data;
  logic [NUM_RD-1:0]               rd_ready;
  logic [NUM_WR-1:0]               wr_en;
  logic [NUM_WR-1:0][TAG_W-1:0]    wr_tag;
  logic [NUM_WR-1:0][XLEN-1:0]     wr_data;
  logic [NUM_ALLOC-1:0]            alloc_en;
  logic [NUM_ALLOC-1:0][TAG_W-1:0] alloc_tag;

  modport master (
    output rd_tag, wr_en, wr_tag, wr_data, alloc_en, alloc_tag,
    input  rd_data, rd_ready
  );

  modport slave (
    input  rd_tag, wr_en, wr_tag, wr_data, alloc_en, alloc_tag,
    output rd_data, rd_ready
  );
endinterface

// File: rtl/prf_mp.sv
// Multi-port physical register file with a per-tag ready scoreboard. Tag 0 reads as zero and is always ready.
// Reads are combinational. Writes and allocs take effect at the next edge. Define PRF_BYPASS_EN to forward same-cycle writes.
module prf_mp #(
  parameter int PHYS_REG_SZ = 64,
  parameter int XLEN        = 32,
  parameter int NUM_RD      = 4,
  parameter int NUM_WR      = 2,
  parameter int NUM_ALLOC   = 2
) (
  input  logic     clock,
  input  logic     reset,
  prf_mp_if.slave  prf
);
  localparam int TAG_W = $clog2(PHYS_REG_SZ);

  logic [XLEN-1:0]        data_q [PHYS_REG_SZ-1:1];
  logic [PHYS_REG_SZ-1:1] ready_q;

  // Later ports overwrite earlier ones, and allocs come after writes, so an alloc clears ready even on a write hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 1; r < PHYS_REG_SZ; r++) begin
        data_q[r] <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (prf.wr_en[i] && prf.wr_tag[i] != '0) begin
          data_q[prf.wr_tag[i]]  <= prf.wr_data[i];
          ready_q[prf.wr_tag[i]] <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        if (prf.alloc_en[j] && prf.alloc_tag[j] != '0) begin
          ready_q[prf.alloc_tag[j]] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      logic            alloc_hit;
      logic [TAG_W-1:0] tag;
      alloc_hit      = 1'b0;
      tag            = prf.rd_tag[p];
      prf.rd_data[p]  = '0;
      prf.rd_ready[p] = 1'b1;
      if (tag != '0) begin
        prf.rd_data[p]  = data_q[tag];
        prf.rd_ready[p] = ready_q[tag];
`ifdef PRF_BYPASS_EN
        for (int j = 0; j < NUM_ALLOC; j++) begin
          if (prf.alloc_en[j] && prf.alloc_tag[j] == tag) begin
            alloc_hit = 1'b1;
          end
        end
        // A same-cycle realloc hides the in-flight write, so the stored state is returned.
        if (!alloc_hit) begin
          for (int i = 0; i < NUM_WR; i++) begin
            if (prf.wr_en[i] && prf.wr_tag[i] == tag) begin
              prf.rd_data[p]  = prf.wr_data[i];
              prf.rd_ready[p] = 1'b1;
            end
          end
        end
`endif
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WR; i++) begin
        for (int k = i + 1; k < NUM_WR; k++) begin
          assert (!(prf.wr_en[i] && prf.wr_en[k] && prf.wr_tag[i] != '0 && prf.wr_tag[i] == prf.wr_tag[k]))
          else $warning("prf_mp: write ports %0d and %0d collide on tag %0d", i, k, prf.wr_tag[i]);
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_prf_mp.sv
// Directed vector table plus a randomized run on a wider configuration, checked against an array-based scoreboard.
module tb_prf_mp;
  logic clk;
  logic rst;

  prf_mp_if #(.PHYS_REG_SZ(64), .XLEN(32), .NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(2)) bus ();
  prf_mp_if #(.PHYS_REG_SZ(128), .XLEN(32), .NUM_RD(6), .NUM_WR(3), .NUM_ALLOC(2)) bus_r ();

  prf_mp #(.PHYS_REG_SZ(64), .XLEN(32), .NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(2))
    dut (.clock(clk), .reset(rst), .prf(bus));
  prf_mp #(.PHYS_REG_SZ(128), .XLEN(32), .NUM_RD(6), .NUM_WR(3), .NUM_ALLOC(2))
    dut_r (.clock(clk), .reset(rst), .prf(bus_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [5:0]  wt0, wt1;
    logic [31:0] wd0, wd1;
    logic [1:0]  ae;
    logic [5:0]  at0, at1;
    logic [5:0]  rt;
    logic [31:0] ed;
    logic        er;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational reads mid-cycle, then let the edge commit it.
  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.wr_en      = v.we;
    bus.wr_tag[0]  = v.wt0;
    bus.wr_tag[1]  = v.wt1;
    bus.wr_data[0] = v.wd0;
    bus.wr_data[1] = v.wd1;
    bus.alloc_en   = v.ae;
    bus.alloc_tag[0] = v.at0;
    bus.alloc_tag[1] = v.at1;
    for (int p = 0; p < 4; p++) bus.rd_tag[p] = v.rt;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s.data%0d", v.name, p), bus.rd_data[p], v.ed);
      chk($sformatf("%s.ready%0d", v.name, p), {31'b0, bus.rd_ready[p]}, {31'b0, v.er});
    end
    @(posedge clk);
  endtask

  // Scoreboard for the wide instance.
  logic [31:0] m_data [128];
  logic        m_rdy  [128];

  initial begin
    vec_t vt [15];
    vec_t v;
    logic [31:0] byp_d;
    logic [31:0] exp_d;
    logic        exp_r;
    logic        ahit;

    rst = 1'b1;
    bus.wr_en = '0; bus.wr_tag = '0; bus.wr_data = '0;
    bus.alloc_en = '0; bus.alloc_tag = '0; bus.rd_tag = '0;
    bus_r.wr_en = '0; bus_r.wr_tag = '0; bus_r.wr_data = '0;
    bus_r.alloc_en = '0; bus_r.alloc_tag = '0; bus_r.rd_tag = '0;

    // Reset held two cycles with a write to tag 5 that must be discarded.
    bus.wr_en = 2'b01; bus.wr_tag[0] = 6'd5; bus.wr_data[0] = 32'hAA;
    bus.rd_tag[0] = 6'd0; bus.rd_tag[1] = 6'd1; bus.rd_tag[2] = 6'd63; bus.rd_tag[3] = 6'd5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        chk($sformatf("in_reset%0d.data%0d", c, p), bus.rd_data[p], 32'h0);
        chk($sformatf("in_reset%0d.ready%0d", c, p), {31'b0, bus.rd_ready[p]}, 32'h1);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = '0;
    for (int p = 0; p < 4; p++) bus.rd_tag[p] = 6'd5;
    #1;
    chk("reset_drops_wr5.data", bus.rd_data[0], 32'h0);
    chk("reset_drops_wr5.ready", {31'b0, bus.rd_ready[0]}, 32'h1);

    //           name              we     wt0    wt1    wd0           wd1     ae     at0    at1    rt     exp data      rdy
    vt[0]  = '{"rst_t0",         2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd0,  32'h0,        1'b1};
    vt[1]  = '{"rst_t1",         2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd1,  32'h0,        1'b1};
    vt[2]  = '{"rst_t63",        2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd63, 32'h0,        1'b1};
    vt[3]  = '{"alloc7",         2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b01, 6'd7,  6'd0,  6'd0,  32'h0,        1'b1};
    vt[4]  = '{"t7_notready",    2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd7,  32'h0,        1'b0};
    vt[5]  = '{"wr7",            2'b01, 6'd7,  6'd0,  32'hDEADBEEF, 32'h0,  2'b00, 6'd0,  6'd0,  6'd1,  32'h0,        1'b1};
    vt[6]  = '{"t7_written",     2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd7,  32'hDEADBEEF, 1'b1};
    vt[7]  = '{"t0_wr_alloc",    2'b01, 6'd0,  6'd0,  32'h1234,     32'h0,  2'b01, 6'd0,  6'd0,  6'd0,  32'h0,        1'b1};
    vt[8]  = '{"t0_after",       2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd0,  32'h0,        1'b1};
    vt[9]  = '{"ww_collide9",    2'b11, 6'd9,  6'd9,  32'h11,       32'h22, 2'b00, 6'd0,  6'd0,  6'd7,  32'hDEADBEEF, 1'b1};
    vt[10] = '{"t9_hi_port",     2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd9,  32'h22,       1'b1};
    vt[11] = '{"alloc_wr12",     2'b10, 6'd0,  6'd12, 32'h0,        32'h55, 2'b10, 6'd0,  6'd12, 6'd9,  32'h22,       1'b1};
    vt[12] = '{"t12_alloc_wins", 2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd12, 32'h55,       1'b0};
    vt[13] = '{"dup_alloc9",     2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b11, 6'd9,  6'd9,  6'd12, 32'h55,       1'b0};
    vt[14] = '{"t9_cleared",     2'b00, 6'd0,  6'd0,  32'h0,        32'h0,  2'b00, 6'd0,  6'd0,  6'd9,  32'h22,       1'b0};
    for (int i = 0; i < 15; i++) apply(vt[i]);

    // Same-cycle write and read of tag 3, then the same with a realloc of tag 3.
`ifdef PRF_BYPASS_EN
    byp_d = 32'h77;
`else
    byp_d = 32'h0;
`endif
    v = '{"byp_wr3",        2'b01, 6'd3, 6'd0, 32'h77, 32'h0, 2'b00, 6'd0, 6'd0, 6'd3, byp_d,  1'b1}; apply(v);
    v = '{"t3_next",        2'b00, 6'd0, 6'd0, 32'h0,  32'h0, 2'b00, 6'd0, 6'd0, 6'd3, 32'h77, 1'b1}; apply(v);
    v = '{"byp_wr3_alloc3", 2'b01, 6'd3, 6'd0, 32'h99, 32'h0, 2'b01, 6'd3, 6'd0, 6'd3, 32'h77, 1'b1}; apply(v);
    v = '{"t3_realloc",     2'b00, 6'd0, 6'd0, 32'h0,  32'h0, 2'b00, 6'd0, 6'd0, 6'd3, 32'h99, 1'b0}; apply(v);
    v = '{"t0_forever",     2'b00, 6'd0, 6'd0, 32'h0,  32'h0, 2'b00, 6'd0, 6'd0, 6'd0, 32'h0,  1'b1}; apply(v);

    // Randomized traffic on the wide instance; it has sat idle since reset.
    for (int t = 0; t < 128; t++) begin
      m_data[t] = '0;
      m_rdy[t]  = 1'b1;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        bus_r.wr_en[i]   = ($urandom_range(0, 2) != 0);
        bus_r.wr_tag[i]  = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
        bus_r.wr_data[i] = $urandom;
        for (int k = 0; k < i; k++)
          if (bus_r.wr_en[k] && bus_r.wr_tag[k] == bus_r.wr_tag[i]) bus_r.wr_en[i] = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
        bus_r.alloc_en[j]  = ($urandom_range(0, 2) == 0);
        bus_r.alloc_tag[j] = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      end
      for (int p = 0; p < 6; p++)
        bus_r.rd_tag[p] = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      #1;
      for (int p = 0; p < 6; p++) begin
        int t;
        t = int'(bus_r.rd_tag[p]);
        exp_d = m_data[t];
        exp_r = m_rdy[t];
        ahit  = 1'b0;
        for (int j = 0; j < 2; j++)
          if (bus_r.alloc_en[j] && int'(bus_r.alloc_tag[j]) == t) ahit = 1'b1;
`ifdef PRF_BYPASS_EN
        for (int i = 0; i < 3; i++)
          if (!ahit && bus_r.wr_en[i] && int'(bus_r.wr_tag[i]) == t) begin
            exp_d = bus_r.wr_data[i];
            exp_r = 1'b1;
          end
`endif
        if (t == 0) begin
          exp_d = '0;
          exp_r = 1'b1;
        end
        chk($sformatf("rand%0d.data%0d", cyc, p), bus_r.rd_data[p], exp_d);
        chk($sformatf("rand%0d.ready%0d", cyc, p), {31'b0, bus_r.rd_ready[p]}, {31'b0, exp_r});
      end
      for (int i = 0; i < 3; i++) begin
        if (bus_r.wr_en[i] && bus_r.wr_tag[i] != 0) begin
          m_data[int'(bus_r.wr_tag[i])] = bus_r.wr_data[i];
          m_rdy[int'(bus_r.wr_tag[i])]  = 1'b1;
        end
      end
      for (int j = 0; j < 2; j++)
        if (bus_r.alloc_en[j] && bus_r.alloc_tag[j] != 0) m_rdy[int'(bus_r.alloc_tag[j])] = 1'b0;
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prf_mp.md
Name: prf_mp

Overview:
- Parametrised multi-port physical register file for the R10K-style out-of-order core, with a per-register ready scoreboard.
- Issue reads operands and their ready state through NUM_RD ports. Complete/CDB writes results through NUM_WR ports.
- Dispatch marks newly allocated destination tags not-ready through NUM_ALLOC ports.
- Physical register 0 is hardwired to zero and is always ready.

Parameters:
- PHYS_REG_SZ, 64, number of physical registers (power of two, >= 4)
- XLEN, 32, data width
- NUM_RD, 4, read ports (2 per issued instruction)
- NUM_WR, 2, write ports (CDB width)
- NUM_ALLOC, 2, allocate ports (dispatch width)
- TAG_W, $clog2(PHYS_REG_SZ), tag width (derived; not overridden)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd_tag  in  NUM_RD x TAG_W  read tags
- rd_data  out  NUM_RD x XLEN  read data
- rd_ready  out  NUM_RD  ready bit of each read tag
- wr_en  in  NUM_WR  write valid
- wr_tag  in  NUM_WR x TAG_W  write tag
- wr_data  in  NUM_WR x XLEN  write data
- alloc_en  in  NUM_ALLOC  allocate valid
- alloc_tag  in  NUM_ALLOC x TAG_W  freshly allocated destination tag

Behaviour:
- Storage: registers 1..PHYS_REG_SZ-1 hold data (XLEN) and ready (1 bit). Tag 0 has no storage.
- Reset: clock and reset are one clock domain; reset is synchronous and active-high. On a reset edge, every data entry goes to 0 and every ready bit to 1 (initial arch map points at ready regs). Reset overrides all same-cycle writes and allocs. Outputs are combinational, so during and after reset, reads return data 0 and ready 1.
- Read, combinational, 0-cycle latency:
  - rd_tag==0 -> rd_data=0, rd_ready=1, regardless of bypass or writes.
  - Otherwise the stored value, or the forwarded value per PRF_BYPASS_EN.
- Write, effective on the next posedge:
  - For each i with wr_en[i] && wr_tag[i]!=0: data[wr_tag[i]] <= wr_data[i] and ready <= 1.
  - Writes to tag 0 are dropped.
- Write-write collision (two ports, same tag, same cycle): the highest port index wins for data. This is illegal in the pipeline, but resolved deterministically. Under `ifndef SYNTHESIS`, an immediate assertion flags it.
- Allocate, next posedge: for each j with alloc_en[j] && alloc_tag[j]!=0, ready[alloc_tag[j]] <= 0. Data is unchanged.
- Alloc and write to the same tag in the same cycle: data is written, and ready ends 0 (allocate wins). This covers a tag freed and reallocated in the same cycle.
- Duplicate alloc tags across ports: harmless (both clear).
- Ports are fully independent. Unselected entries hold.
- No stalls and no handshake. Every valid write or alloc is accepted every cycle.

Optional Feature:
- Macro: PRF_BYPASS_EN.
- Defined:
  - Each read port compares its tag against all wr_en/wr_tag in the same cycle (tag!=0).
  - On a match, rd_data = the matching wr_data (highest index on multi-match) and rd_ready = 1.
  - Forwarding is suppressed when any alloc_en/alloc_tag in the same cycle matches the read tag. In that case the stored data and ready are returned (0-cycle alloc visibility is not required).
- Undefined: reads return stored state only. Same-cycle write data is visible on the cycle after the edge.

Test Plan:
- Reset: assert reset 2 cycles, then read tags 0, 1, 63 -> rd_data=0 and rd_ready=1 on all ports. Write tag 5=0xAA together with reset -> after reset, tag 5 reads 0.
- Alloc/write lifecycle:
  - alloc tag 7 -> next cycle rd_ready=0.
  - wr tag 7=0xDEADBEEF -> next cycle rd_data=0xDEADBEEF and rd_ready=1 on all 4 read ports.
- Tag 0: write 0x1234 to tag 0 and alloc tag 0 -> reads of tag 0 give 0 and ready 1 forever.
- Collisions:
  - wr0 and wr1 both tag 9 with 0x11 and 0x22 -> tag 9 reads 0x22 (assertion fires in sim).
  - alloc tag 12 and write tag 12=0x55 in the same cycle -> data 0x55, ready 0.
- Bypass, with PRF_BYPASS_EN:
  - wr tag 3=0x77 and rd tag 3 in the same cycle -> rd_data=0x77, rd_ready=1 in that cycle.
  - Repeat with alloc tag 3 in the same cycle -> old data returned and old ready (1) returned.
- Without PRF_BYPASS_EN: same stimulus -> old value in that cycle, 0x77 the next cycle.
- Random: 10k cycles of random writes, allocs and reads against a scoreboard model, with NUM_RD=6, NUM_WR=3, PHYS_REG_SZ=128 -> zero mismatches.
